dmem_lsu: RTL and testbench

//  Load/store unit directly upstream of the byte-enabled data memory (dual 15-bit word addr, clk/2 internal RMW).

---
 rtl/lsu_pkg.sv | 35 +++
 rtl/lsu_load_align.sv | 38 +++
 rtl/dmem_lsu.sv | 175 +++++++++++++++++
 tb/tb_dmem_lsu.sv | 381 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lsu_pkg.sv
// Shared definitions for the data-memory load/store unit.
//   - RV32 funct3 size/sign codes used by loads and stores
//   - FSM state encodings for dmem_lsu
//   - req_is_err: decides whether a request is rejected without a memory access
package lsu_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_ACCESS = 2'd1;
    localparam logic [1:0] ST_RESP   = 2'd2;

    // Stores only have B/H/W. Loads additionally have the unsigned B/H forms.
    // Alignment only matters for H and W; funct3[1:0] gives the size for every
    // legal code, and illegal codes are already flagged by bad_f3.
    function automatic logic req_is_err(input logic       we,
                                        input logic [2:0] f3,
                                        input logic [1:0] off);
        logic bad_f3;
        logic misaligned;
        if (we)
            bad_f3 = (f3 > F3_W);
        else
            bad_f3 = !(f3 == F3_B || f3 == F3_H || f3 == F3_W ||
                       f3 == F3_BU || f3 == F3_HU);
        misaligned = ((f3[1:0] == 2'b01) && off[0]) ||
                     ((f3[1:0] == 2'b10) && (off != 2'b00));
        return bad_f3 | misaligned;
    endfunction

endpackage

// File: rtl/lsu_load_align.sv
// Load data alignment and extension (purely combinational).
//   dm_q      in  32  raw memory word
//   addr_lo   in  2   byte offset within the word
//   funct3    in  3   load size/sign code
//   load_data out 32  selected lane(s), sign- or zero-extended
module lsu_load_align
    import lsu_pkg::*;
(
    input  logic [31:0] dm_q,
    input  logic [1:0]  addr_lo,
    input  logic [2:0]  funct3,
    output logic [31:0] load_data
);

    logic [7:0]  lane [4];
    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    for (genvar gi = 0; gi < 4; gi++) begin : g_lane
        assign lane[gi] = dm_q[gi*8 +: 8];
    end

    assign byte_sel = lane[addr_lo];
    assign half_sel = addr_lo[1] ? dm_q[31:16] : dm_q[15:0];

    always_comb begin
        load_data = '0;
        case (funct3)
            F3_B:    load_data = {{24{byte_sel[7]}}, byte_sel};
            F3_BU:   load_data = {24'd0, byte_sel};
            F3_H:    load_data = {{16{half_sel[15]}}, half_sel};
            F3_HU:   load_data = {16'd0, half_sel};
            F3_W:    load_data = dm_q;
            default: load_data = '0;
        endcase
    end

endmodule

// File: rtl/dmem_lsu.sv
// Load/store unit in front of a byte-enabled data memory whose internal
// read-modify-write runs on a divided clock of unknown phase.
//   clk, rst_n                 clock, synchronous active-low reset
//   req_valid/req_ready        request handshake; one request in flight
//   req_we/req_funct3          store flag and RV32 size/sign code
//   req_addr/req_wdata         byte address and store data
//   resp_valid/resp_rdata/err  one-cycle response pulse with load data
//   dm_rdaddr/dm_wraddr        word address to memory (same value)
//   dm_wren/dm_byteena/dm_data write enable, lane enables, replicated data
//   dm_q                       memory read data
// Memory controls are registered at the handshake and held for the whole
// access window, so the memory sees stable inputs whichever phase its
// divided clock happens to be in.
module dmem_lsu
    import lsu_pkg::*;
#(
    parameter int RD_WAIT = 3,
    parameter int WR_WAIT = 5,
    parameter int AW      = 15
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          req_valid,
    output logic          req_ready,
    input  logic          req_we,
    input  logic [2:0]    req_funct3,
    input  logic [31:0]   req_addr,
    input  logic [31:0]   req_wdata,
    output logic          resp_valid,
    output logic [31:0]   resp_rdata,
    output logic          resp_err,
    output logic [AW-1:0] dm_rdaddr,
    output logic [AW-1:0] dm_wraddr,
    output logic          dm_wren,
    output logic [3:0]    dm_byteena,
    output logic [31:0]   dm_data,
    input  logic [31:0]   dm_q
);

    localparam int MAX_WAIT = (RD_WAIT > WR_WAIT) ? RD_WAIT : WR_WAIT;
    localparam int CW       = $clog2(MAX_WAIT + 1);

    logic [1:0]    state_reg;
    logic [CW-1:0] cnt_reg;
    logic          we_reg;
    logic [2:0]    f3_reg;
    logic [1:0]    off_reg;
    logic [AW-1:0] addr_reg;
    logic          wren_reg;
    logic [3:0]    be_reg;
    logic [31:0]   data_reg;
    logic          resp_valid_reg;
    logic          resp_err_reg;
    logic [31:0]   resp_rdata_reg;

    logic          req_fire;
    logic          req_err_next;
    logic [3:0]    be_next;
    logic [31:0]   data_next;
    logic [31:0]   load_data;

    // Upper address bits are deliberately dropped: the word address wraps.
    logic          unused_addr_hi;
    assign unused_addr_hi = ^req_addr[31:AW+2];

    assign req_ready    = (state_reg == ST_IDLE);
    assign req_fire     = req_valid && req_ready;
    assign req_err_next = req_is_err(req_we, req_funct3, req_addr[1:0]);

    // Store lane steering: each byte lane picks the wdata byte that lands on
    // it after replication, and is enabled if the access covers it.
    for (genvar gi = 0; gi < 4; gi++) begin : g_store_lane
        always_comb begin
            data_next[gi*8 +: 8] = req_wdata[gi*8 +: 8];
            be_next[gi]          = 1'b1;
            case (req_funct3[1:0])
                2'b00: begin
                    data_next[gi*8 +: 8] = req_wdata[7:0];
                    be_next[gi]          = (req_addr[1:0] == 2'(gi));
                end
                2'b01: begin
                    data_next[gi*8 +: 8] = req_wdata[(gi%2)*8 +: 8];
                    be_next[gi]          = (req_addr[1] == 1'(gi/2));
                end
                default: ;
            endcase
        end
    end

    lsu_load_align u_load_align (
        .dm_q      (dm_q),
        .addr_lo   (off_reg),
        .funct3    (f3_reg),
        .load_data (load_data)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg      <= ST_IDLE;
            cnt_reg        <= '0;
            we_reg         <= 1'b0;
            f3_reg         <= '0;
            off_reg        <= '0;
            addr_reg       <= '0;
            wren_reg       <= 1'b0;
            be_reg         <= '0;
            data_reg       <= '0;
            resp_valid_reg <= 1'b0;
            resp_err_reg   <= 1'b0;
            resp_rdata_reg <= '0;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    if (req_fire) begin
                        we_reg  <= req_we;
                        f3_reg  <= req_funct3;
                        off_reg <= req_addr[1:0];
                        if (req_err_next) begin
                            // Rejected: answer straight away, memory untouched.
                            state_reg      <= ST_RESP;
                            resp_valid_reg <= 1'b1;
                            resp_err_reg   <= 1'b1;
                            resp_rdata_reg <= '0;
                        end else begin
                            state_reg <= ST_ACCESS;
                            cnt_reg   <= req_we ? CW'(WR_WAIT - 1) : CW'(RD_WAIT - 1);
                            addr_reg  <= req_addr[AW+1:2];
                            wren_reg  <= req_we;
                            be_reg    <= req_we ? be_next : 4'b0000;
                            if (req_we)
                                data_reg <= data_next;
                        end
                    end
                end
                ST_ACCESS: begin
                    if (cnt_reg == '0) begin
                        // Last cycle of the window: dm_q is now valid for loads.
                        state_reg      <= ST_RESP;
                        wren_reg       <= 1'b0;
                        be_reg         <= 4'b0000;
                        resp_valid_reg <= 1'b1;
                        resp_err_reg   <= 1'b0;
                        resp_rdata_reg <= we_reg ? 32'd0 : load_data;
                    end else begin
                        cnt_reg <= cnt_reg - 1'b1;
                    end
                end
                ST_RESP: begin
                    state_reg      <= ST_IDLE;
                    resp_valid_reg <= 1'b0;
                    resp_err_reg   <= 1'b0;
                    resp_rdata_reg <= '0;
                end
                default: begin
                    state_reg      <= ST_IDLE;
                    wren_reg       <= 1'b0;
                    be_reg         <= 4'b0000;
                    resp_valid_reg <= 1'b0;
                    resp_err_reg   <= 1'b0;
                    resp_rdata_reg <= '0;
                end
            endcase
        end
    end

    assign dm_rdaddr  = addr_reg;
    assign dm_wraddr  = addr_reg;
    assign dm_wren    = wren_reg;
    assign dm_byteena = be_reg;
    assign dm_data    = data_reg;
    assign resp_valid = resp_valid_reg;
    assign resp_err   = resp_err_reg;
    assign resp_rdata = resp_rdata_reg;

endmodule

// File: tb/tb_dmem_lsu.sv
// Self-checking bench for dmem_lsu. A behavioural byte-enabled memory with a
// clk/2 read-modify-write cycle sits behind the DUT; a separate word-array
// reference model predicts load results, lane enables and error outcomes.
module tb_dmem_lsu;

    localparam int RD_WAIT = 3;
    localparam int WR_WAIT = 5;
    localparam int AW      = 15;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          req_valid;
    logic          req_ready;
    logic          req_we;
    logic [2:0]    req_funct3;
    logic [31:0]   req_addr;
    logic [31:0]   req_wdata;
    logic          resp_valid;
    logic [31:0]   resp_rdata;
    logic          resp_err;
    logic [AW-1:0] dm_rdaddr;
    logic [AW-1:0] dm_wraddr;
    logic          dm_wren;
    logic [3:0]    dm_byteena;
    logic [31:0]   dm_data;
    logic [31:0]   dm_q;

    int total = 0;
    int bad   = 0;

    dmem_lsu #(.RD_WAIT(RD_WAIT), .WR_WAIT(WR_WAIT), .AW(AW)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
        .dm_rdaddr(dm_rdaddr), .dm_wraddr(dm_wraddr), .dm_wren(dm_wren),
        .dm_byteena(dm_byteena), .dm_data(dm_data), .dm_q(dm_q)
    );

    always #5 clk = ~clk;

    // Memory behind the DUT: acts only on every other clk edge (divided clock),
    // reading the old word and merging enabled lanes in the same edge.
    logic [31:0] mem [0:32767];
    logic        phase = 1'b0;
    always @(posedge clk) begin
        phase <= ~phase;
        if (phase) begin
            dm_q <= mem[dm_rdaddr];
            if (dm_wren)
                for (int l = 0; l < 4; l++)
                    if (dm_byteena[l]) mem[dm_wraddr][8*l +: 8] <= dm_data[8*l +: 8];
        end
    end

    // ---------------- reference model ----------------
    logic [31:0] ref_mem [0:32767];

    function automatic int size_of(input logic [2:0] f3);
        return 1 << f3[1:0];
    endfunction

    function automatic logic model_err(input logic we, input logic [2:0] f3, input logic [1:0] off);
        bit legal;
        if (f3 == 3 || f3 == 6 || f3 == 7) legal = 0;
        else if (we && f3 > 2)             legal = 0;
        else                               legal = 1;
        return !legal || ((int'(off) % size_of(f3)) != 0);
    endfunction

    function automatic logic [31:0] model_load(input logic [31:0] word, input logic [1:0] off,
                                               input logic [2:0] f3);
        logic [31:0]        sh;
        logic signed [7:0]  sb;
        logic signed [15:0] shw;
        sh  = word >> (8 * int'(off));
        sb  = sh[7:0];
        shw = sh[15:0];
        case (f3)
            3'd0:    return 32'(sb);
            3'd4:    return {24'd0, sh[7:0]};
            3'd1:    return 32'(shw);
            3'd5:    return {16'd0, sh[15:0]};
            default: return sh;
        endcase
    endfunction

    function automatic logic [3:0] model_be(input logic [2:0] f3, input logic [1:0] off);
        logic [3:0] be = '0;
        for (int i = 0; i < size_of(f3); i++) be[int'(off) + i] = 1'b1;
        return be;
    endfunction

    function automatic logic [31:0] model_data(input logic [2:0] f3, input logic [31:0] wdata);
        logic [31:0] d;
        for (int l = 0; l < 4; l++) d[8*l +: 8] = wdata[8*(l % size_of(f3)) +: 8];
        return d;
    endfunction

    task automatic model_store(input logic [2:0] f3, input logic [31:0] addr, input logic [31:0] wdata);
        int w;
        w = int'(addr[16:2]);
        for (int i = 0; i < size_of(f3); i++)
            ref_mem[w][8*(int'(addr[1:0]) + i) +: 8] = wdata[8*i +: 8];
    endtask

    // ---------------- single-request driver ----------------
    int          obs_lat, obs_wren_cnt;
    logic [3:0]  obs_be_or;
    logic [31:0] obs_data, obs_rdata;
    logic [AW-1:0] obs_rdaddr, obs_wraddr;
    logic        obs_err, obs_moved, obs_after_valid, obs_after_ready;

    task automatic do_req(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                          input logic [31:0] wdata);
        int n;
        int cyc;
        bit got;
        @(negedge clk);
        req_we = we; req_funct3 = f3; req_addr = addr; req_wdata = wdata; req_valid = 1'b1;
        n = 0;
        while (!req_ready && n < 50) begin @(negedge clk); n++; end
        if (!req_ready) begin
            total++; bad++;
            $display("FAIL handshake_timeout: req_ready=%0b required 1", req_ready);
            req_valid = 1'b0;
            return;
        end
        if (we && !model_err(we, f3, addr[1:0])) model_store(f3, addr, wdata);
        @(posedge clk); #1;
        req_valid = 1'b0; req_we = $urandom; req_funct3 = 3'($urandom);
        req_addr = $urandom; req_wdata = $urandom;
        obs_wren_cnt = 0; obs_be_or = '0; obs_data = '0; obs_moved = 0; obs_lat = 0;
        obs_rdata = 'x; obs_err = 'x;
        got = 0;
        cyc = 2;
        while (!got && cyc < 60) begin
            @(negedge clk);
            if (cyc == 2) begin obs_rdaddr = dm_rdaddr; obs_wraddr = dm_wraddr; end
            else if (!resp_valid && (dm_rdaddr !== obs_rdaddr || dm_wraddr !== obs_wraddr)) obs_moved = 1;
            if (dm_wren) begin obs_wren_cnt++; obs_data = dm_data; end
            if (!resp_valid) obs_be_or |= dm_byteena;
            if (resp_valid) begin
                obs_lat = cyc; obs_rdata = resp_rdata; obs_err = resp_err; got = 1;
            end
            cyc++;
        end
        if (!got) begin
            total++; bad++;
            $display("FAIL resp_timeout: resp_valid=%0b required 1 within 60 cycles", resp_valid);
        end
        @(negedge clk);
        obs_after_valid = resp_valid;
        obs_after_ready = req_ready;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst_n = 1'b0; req_valid = 1'b0; req_we = 0; req_funct3 = 0; req_addr = 0; req_wdata = 0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        total++; if (req_ready  !== 1'b1) begin bad++; $display("FAIL rst_ready: got %0b want 1", req_ready); end
        total++; if (resp_valid !== 1'b0) begin bad++; $display("FAIL rst_resp_valid: got %0b want 0", resp_valid); end
        total++; if (resp_rdata !== 32'd0) begin bad++; $display("FAIL rst_rdata: got %h want 0", resp_rdata); end
        total++; if (resp_err   !== 1'b0) begin bad++; $display("FAIL rst_err: got %0b want 0", resp_err); end
        total++; if (dm_wren    !== 1'b0) begin bad++; $display("FAIL rst_wren: got %0b want 0", dm_wren); end
        total++; if (dm_byteena !== 4'd0) begin bad++; $display("FAIL rst_byteena: got %b want 0000", dm_byteena); end
        total++; if (dm_rdaddr !== '0 || dm_wraddr !== '0) begin bad++; $display("FAIL rst_addr: got %h/%h want 0", dm_rdaddr, dm_wraddr); end
        total++; if (dm_data    !== 32'd0) begin bad++; $display("FAIL rst_data: got %h want 0", dm_data); end
        $display("reset: ready=%0b wren=%0b", req_ready, dm_wren);
        rst_n = 1'b1;
    endtask

    task automatic test_word();
        do_req(1'b1, 3'b010, 32'h10, 32'hDEADBEEF);
        $display("SW 0x10: be=%b wraddr=%h wren_cycles=%0d lat=%0d", obs_be_or, obs_wraddr, obs_wren_cnt, obs_lat);
        total++; if (obs_be_or !== 4'b1111) begin bad++; $display("FAIL sw_be: got %b want 1111", obs_be_or); end
        total++; if (obs_wraddr !== 15'd4) begin bad++; $display("FAIL sw_wraddr: got %h want 4", obs_wraddr); end
        total++; if (obs_wren_cnt != WR_WAIT) begin bad++; $display("FAIL sw_wren_cycles: got %0d want %0d", obs_wren_cnt, WR_WAIT); end
        total++; if (obs_lat != WR_WAIT + 2) begin bad++; $display("FAIL sw_latency: got %0d want %0d", obs_lat, WR_WAIT + 2); end
        total++; if (obs_after_valid !== 1'b0 || obs_after_ready !== 1'b1) begin bad++; $display("FAIL sw_pulse: valid_after=%0b ready_after=%0b want 0/1", obs_after_valid, obs_after_ready); end
        do_req(1'b0, 3'b010, 32'h10, 32'h0);
        $display("LW 0x10: rdata=%h lat=%0d", obs_rdata, obs_lat);
        total++; if (obs_rdata !== 32'hDEADBEEF) begin bad++; $display("FAIL lw_data: got %h want deadbeef", obs_rdata); end
        total++; if (obs_lat != RD_WAIT + 2) begin bad++; $display("FAIL lw_latency: got %0d want %0d", obs_lat, RD_WAIT + 2); end
        total++; if (obs_wren_cnt != 0 || obs_be_or !== 4'b0000) begin bad++; $display("FAIL lw_no_write: wren_cycles=%0d be=%b want 0/0000", obs_wren_cnt, obs_be_or); end
    endtask

    task automatic test_byte();
        do_req(1'b1, 3'b000, 32'h13, 32'h80);
        $display("SB 0x13: be=%b data=%h", obs_be_or, obs_data);
        total++; if (obs_be_or !== 4'b1000) begin bad++; $display("FAIL sb_be: got %b want 1000", obs_be_or); end
        total++; if (obs_data !== 32'h80808080) begin bad++; $display("FAIL sb_data: got %h want 80808080", obs_data); end
        do_req(1'b0, 3'b000, 32'h13, 32'h0);
        $display("LB 0x13: rdata=%h", obs_rdata);
        total++; if (obs_rdata !== 32'hFFFFFF80) begin bad++; $display("FAIL lb_data: got %h want ffffff80", obs_rdata); end
        do_req(1'b0, 3'b100, 32'h13, 32'h0);
        $display("LBU 0x13: rdata=%h", obs_rdata);
        total++; if (obs_rdata !== 32'h00000080) begin bad++; $display("FAIL lbu_data: got %h want 00000080", obs_rdata); end
        do_req(1'b0, 3'b010, 32'h10, 32'h0);
        $display("LW 0x10: rdata=%h", obs_rdata);
        total++; if (obs_rdata !== 32'h80ADBEEF) begin bad++; $display("FAIL lw_merge: got %h want 80adbeef", obs_rdata); end
    endtask

    task automatic test_half();
        do_req(1'b1, 3'b001, 32'h22, 32'h12348001);
        $display("SH 0x22: be=%b data=%h", obs_be_or, obs_data);
        total++; if (obs_be_or !== 4'b1100) begin bad++; $display("FAIL sh_be: got %b want 1100", obs_be_or); end
        total++; if (obs_data !== 32'h80018001) begin bad++; $display("FAIL sh_data: got %h want 80018001", obs_data); end
        do_req(1'b0, 3'b001, 32'h22, 32'h0);
        $display("LH 0x22: rdata=%h", obs_rdata);
        total++; if (obs_rdata !== 32'hFFFF8001) begin bad++; $display("FAIL lh_data: got %h want ffff8001", obs_rdata); end
        do_req(1'b0, 3'b101, 32'h22, 32'h0);
        $display("LHU 0x22: rdata=%h", obs_rdata);
        total++; if (obs_rdata !== 32'h00008001) begin bad++; $display("FAIL lhu_data: got %h want 00008001", obs_rdata); end
    endtask

    task automatic test_errors();
        logic        e_we [3]  = '{1'b0, 1'b1, 1'b0};
        logic [2:0]  e_f3 [3]  = '{3'b010, 3'b001, 3'b011};
        logic [31:0] e_ad [3]  = '{32'h11, 32'h23, 32'h10};
        for (int i = 0; i < 3; i++) begin
            do_req(e_we[i], e_f3[i], e_ad[i], 32'hFFFFFFFF);
            $display("err req %0d: we=%0b f3=%b addr=%h -> err=%0b rdata=%h lat=%0d wren_cycles=%0d",
                     i, e_we[i], e_f3[i], e_ad[i], obs_err, obs_rdata, obs_lat, obs_wren_cnt);
            total++; if (obs_err !== 1'b1) begin bad++; $display("FAIL err_flag[%0d]: got %0b want 1", i, obs_err); end
            total++; if (obs_lat != 2) begin bad++; $display("FAIL err_latency[%0d]: got %0d want 2", i, obs_lat); end
            total++; if (obs_rdata !== 32'd0) begin bad++; $display("FAIL err_rdata[%0d]: got %h want 0", i, obs_rdata); end
            total++; if (obs_wren_cnt != 0) begin bad++; $display("FAIL err_wren[%0d]: got %0d want 0", i, obs_wren_cnt); end
        end
    endtask

    typedef struct { logic [31:0] rdata; logic err; } exp_t;

    task automatic test_back_to_back(input int idle_pre);
        localparam int N = 8;
        logic        b_we [N];
        logic [2:0]  b_f3 [N];
        logic [31:0] b_ad [N], b_wd [N];
        exp_t        q [$];
        exp_t        e;
        int issued = 0, got = 0, cyc = 0;
        bit hs = 0;
        for (int i = 0; i < N; i++) begin
            b_we[i] = 1'($urandom);
            b_f3[i] = 3'($urandom_range(0, 2));
            b_ad[i] = 32'h200 + 32'($urandom_range(0, 3) * 4);
            b_ad[i][1:0] = 2'($urandom_range(0, 3) & ~(size_of(b_f3[i]) - 1));
            b_wd[i] = $urandom;
        end
        b_we[3] = 1'b0; b_f3[3] = 3'b010; b_ad[3] = 32'h201;
        repeat (idle_pre + 1) @(negedge clk);
        req_we = b_we[0]; req_funct3 = b_f3[0]; req_addr = b_ad[0]; req_wdata = b_wd[0];
        req_valid = 1'b1;
        while (got < N && cyc < 400) begin
            if (resp_valid) begin
                total++;
                if (q.size() == 0) begin bad++; $display("FAIL b2b_extra_resp: resp with none outstanding"); end
                else begin
                    e = q.pop_front();
                    if (resp_rdata !== e.rdata || resp_err !== e.err) begin
                        bad++; $display("FAIL b2b_resp[%0d]: got %h/%0b want %h/%0b", got, resp_rdata, resp_err, e.rdata, e.err);
                    end
                end
                $display("b2b resp %0d: rdata=%h err=%0b", got, resp_rdata, resp_err);
                got++;
                total++; if (req_ready !== 1'b0) begin bad++; $display("FAIL b2b_ready_in_resp: got %0b want 0", req_ready); end
            end
            if (hs) begin
                total++; if (req_ready !== 1'b0) begin bad++; $display("FAIL b2b_ready_busy: got %0b want 0", req_ready); end
            end
            hs = 0;
            if (issued < N && req_ready) begin
                e.err   = model_err(b_we[issued], b_f3[issued], b_ad[issued][1:0]);
                e.rdata = (e.err || b_we[issued]) ? 32'd0 :
                          model_load(ref_mem[int'(b_ad[issued][16:2])], b_ad[issued][1:0], b_f3[issued]);
                if (b_we[issued] && !e.err) model_store(b_f3[issued], b_ad[issued], b_wd[issued]);
                q.push_back(e);
                issued++;
                hs = 1;
            end
            @(posedge clk); #1;
            if (hs) begin
                if (issued < N) begin
                    req_we = b_we[issued]; req_funct3 = b_f3[issued];
                    req_addr = b_ad[issued]; req_wdata = b_wd[issued];
                end else req_valid = 1'b0;
            end
            @(negedge clk);
            cyc++;
        end
        req_valid = 1'b0;
        total++; if (got != N || q.size() != 0) begin bad++; $display("FAIL b2b_count: got %0d responses want %0d", got, N); end
    endtask

    task automatic test_reset_mid_store();
        int seen = 0;
        @(negedge clk);
        req_we = 1'b1; req_funct3 = 3'b010; req_addr = 32'h40; req_wdata = 32'hCAFEF00D; req_valid = 1'b1;
        while (!req_ready) @(negedge clk);
        @(posedge clk); #1; req_valid = 1'b0;
        @(negedge clk); @(negedge clk);
        total++; if (dm_wren !== 1'b1) begin bad++; $display("FAIL mid_wren_before: got %0b want 1", dm_wren); end
        rst_n = 1'b0;
        @(negedge clk);
        $display("reset mid-store: wren=%0b ready=%0b resp_valid=%0b", dm_wren, req_ready, resp_valid);
        total++; if (dm_wren !== 1'b0) begin bad++; $display("FAIL mid_wren_after: got %0b want 0", dm_wren); end
        total++; if (req_ready !== 1'b1) begin bad++; $display("FAIL mid_ready: got %0b want 1", req_ready); end
        rst_n = 1'b1;
        repeat (10) begin
            if (resp_valid) seen++;
            @(negedge clk);
        end
        total++; if (seen != 0) begin bad++; $display("FAIL mid_no_resp: got %0d pulses want 0", seen); end
        do_req(1'b0, 3'b010, 32'h10, 32'h0);
        $display("LW 0x10 after reset: rdata=%h", obs_rdata);
        total++; if (obs_rdata !== ref_mem[4] || obs_err !== 1'b0) begin bad++; $display("FAIL mid_followup: got %h/%0b want %h/0", obs_rdata, obs_err, ref_mem[4]); end
    endtask

    task automatic test_random();
        logic        we, e_err;
        logic [2:0]  f3;
        logic [31:0] a, wd, e_rd;
        for (int i = 0; i < 60; i++) begin
            we = 1'($urandom);
            f3 = 3'($urandom_range(0, 7));
            a  = $urandom;
            a[16:2] = 15'(128 + $urandom_range(0, 7));
            wd = $urandom;
            e_err = model_err(we, f3, a[1:0]);
            e_rd  = (we || e_err) ? 32'd0 : model_load(ref_mem[int'(a[16:2])], a[1:0], f3);
            do_req(we, f3, a, wd);
            $display("rnd %0d: we=%0b f3=%b addr=%h wdata=%h -> rdata=%h err=%0b lat=%0d be=%b",
                     i, we, f3, a, wd, obs_rdata, obs_err, obs_lat, obs_be_or);
            total++; if (obs_err !== e_err) begin bad++; $display("FAIL rnd_err[%0d]: got %0b want %0b", i, obs_err, e_err); end
            total++; if (obs_rdata !== e_rd) begin bad++; $display("FAIL rnd_rdata[%0d]: got %h want %h", i, obs_rdata, e_rd); end
            total++;
            if (obs_lat != (e_err ? 2 : (we ? WR_WAIT + 2 : RD_WAIT + 2))) begin
                bad++; $display("FAIL rnd_latency[%0d]: got %0d", i, obs_lat);
            end
            total++;
            if (obs_wren_cnt != ((we && !e_err) ? WR_WAIT : 0)) begin
                bad++; $display("FAIL rnd_wren_cycles[%0d]: got %0d", i, obs_wren_cnt);
            end
            total++;
            if (obs_be_or !== ((we && !e_err) ? model_be(f3, a[1:0]) : 4'b0000)) begin
                bad++; $display("FAIL rnd_be[%0d]: got %b", i, obs_be_or);
            end
            total++; if (obs_after_valid !== 1'b0) begin bad++; $display("FAIL rnd_pulse[%0d]: got %0b want 0", i, obs_after_valid); end
            if (!e_err) begin
                total++;
                if (obs_rdaddr !== a[16:2] || obs_wraddr !== a[16:2] || obs_moved) begin
                    bad++; $display("FAIL rnd_addr[%0d]: got %h/%h moved=%0b want %h", i, obs_rdaddr, obs_wraddr, obs_moved, a[16:2]);
                end
            end
            if (we && !e_err) begin
                total++;
                if (obs_data !== model_data(f3, wd)) begin
                    bad++; $display("FAIL rnd_data[%0d]: got %h want %h", i, obs_data, model_data(f3, wd));
                end
            end
        end
    endtask

    initial begin
        for (int i = 0; i < 32768; i++) begin mem[i] = '0; ref_mem[i] = '0; end
        dm_q = '0;
        test_reset();
        test_word();
        test_byte();
        test_half();
        test_errors();
        test_back_to_back(0);
        test_back_to_back(1);
        test_reset_mid_store();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
